cdc_handshake_tx: RTL and testbench

//  Source-domain half of a 4-phase req/ack clock-domain crossing for multi-bit data.
//  - Captures a word on data_valid and drives it onto a held-stable bus.
//  - Raises req, then waits for the destination's ack. ack is resynchronized internally.
//  - Completes the return-to-zero phase before accepting the next word.
//  - Pairs with the destination-side receiver: that side synchronizes req, samples
//    bus_data and returns ack.

---
 rtl/cdc_handshake_tx.sv | 87 ++++++++
 tb/tb_cdc_handshake_tx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source half of a 4-phase req/ack crossing for a multi-bit word
module cdc_handshake_tx #(
    parameter int WIDTH        = 8,
    parameter int NUM_OF_STAGE = 3,
    parameter int TIMEOUT      = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             ready,
    output logic [WIDTH-1:0] bus_data,
    output logic             req,
    input  logic             ack,
    output logic             done,
    output logic             dropped,
    output logic             timeout_err
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIM = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;
    state_t                  r_state;
    logic [NUM_OF_STAGE-2:0] r_ack_sync;
    logic [CW-1:0]           r_cnt;
    logic                    w_ack_s;
    logic                    w_to;
    // The FSM state register is the last synchronizer stage, so ack reaches req/done after NUM_OF_STAGE edges
    assign w_ack_s = r_ack_sync[NUM_OF_STAGE-2];
    assign w_to    = (TIMEOUT > 0) && (r_cnt == LIM);
    assign ready   = (r_state == IDLE);
    // Resynchronize the asynchronous ack into the source clock domain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync[0] <= ack;
            for (int i = 1; i < NUM_OF_STAGE - 1; i++) r_ack_sync[i] <= r_ack_sync[i-1];
        end
    end
    // Handshake FSM with registered req/bus/pulse outputs and per-state timeout counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            bus_data    <= '0;
            req         <= 1'b0;
            done        <= 1'b0;
            dropped     <= 1'b0;
            timeout_err <= 1'b0;
            r_cnt       <= '0;
        end else begin
            done        <= 1'b0;
            timeout_err <= 1'b0;
            dropped     <= data_valid && (r_state != IDLE);
            r_cnt       <= r_cnt + 1'b1;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (data_valid) begin
                        bus_data <= data_in;
                        req      <= 1'b1;
                        r_state  <= REQ_HI;
                    end
                end
                REQ_HI: begin
                    if (w_ack_s || w_to) begin
                        req         <= 1'b0;
                        timeout_err <= !w_ack_s;
                        r_cnt       <= '0;
                        r_state     <= REQ_LO;
                    end
                end
                REQ_LO: begin
                    if (!w_ack_s || w_to) begin
                        done        <= !w_ack_s;
                        timeout_err <= w_ack_s;
                        r_cnt       <= '0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    req     <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx: directed checks of the source-side 4-phase handshake
module tb_cdc_handshake_tx;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] data_in;
    logic       dv, dv2;
    logic       ack_man, ack2, dest_en;
    logic       r_dest = 1'b0;
    logic       ack;
    logic       ready, req, done, dropped, terr;
    logic [7:0] bus;
    logic       ready2, req2, done2, dropped2, terr2;
    logic [7:0] bus2;
    int         n_chk = 0;
    int         n_pass = 0;

    cdc_handshake_tx u_dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(dv),
        .ready(ready), .bus_data(bus), .req(req), .ack(ack),
        .done(done), .dropped(dropped), .timeout_err(terr)
    );

    cdc_handshake_tx #(.TIMEOUT(16)) u_dut_to (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(dv2),
        .ready(ready2), .bus_data(bus2), .req(req2), .ack(ack2),
        .done(done2), .dropped(dropped2), .timeout_err(terr2)
    );

    always #5 clk = ~clk;

    // Destination model: echoes req back as ack one cycle later
    always @(posedge clk) r_dest <= req;
    assign ack = dest_en ? r_dest : ack_man;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] words[2];
        int   idx, sent, dones;
        logic acc, busy, prev_req, prev_hold;
        logic [7:0] prev_bus;
        words = '{8'h01, 8'h02};
        reset_n = 1'b0; ack_man = 1'b1; ack2 = 1'b0; dv = 1'b0; dv2 = 1'b0;
        data_in = 8'h00; dest_en = 1'b0;
        // 1. reset with ack high
        nclk(2);
        check("rst_req", req, 0);
        check("rst_bus", bus, 0);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_dropped", dropped, 0);
        check("rst_terr", terr, 0);
        ack_man = 1'b0;
        nclk(4);
        reset_n = 1'b1;
        nclk(2);
        check("idle_ready", ready, 1);
        check("idle_req", req, 0);
        // 2/3. single transfer with a busy drop
        data_in = 8'hA5; dv = 1'b1;
        nclk(1);
        check("t2_req", req, 1);
        check("t2_bus", bus, 8'hA5);
        check("t2_ready", ready, 0);
        data_in = 8'h3C;
        nclk(1);
        dv = 1'b0;
        check("t3_dropped", dropped, 1);
        check("t3_bus", bus, 8'hA5);
        nclk(1);
        check("t3_dropped_clr", dropped, 0);
        ack_man = 1'b1;
        nclk(2);
        check("t2_req_hold", req, 1);
        nclk(1);
        check("t2_req_fall", req, 0);
        check("t2_ready_lo", ready, 0);
        check("t2_bus_lo", bus, 8'hA5);
        ack_man = 1'b0;
        nclk(2);
        check("t2_done_early", done, 0);
        nclk(1);
        check("t2_done", done, 1);
        check("t2_ready_done", ready, 1);
        check("t2_bus_done", bus, 8'hA5);
        nclk(1);
        check("t2_done_clr", done, 0);
        check("t2_bus_after", bus, 8'hA5);
        // 4. back-to-back with data_valid held high
        dest_en = 1'b1;
        idx = 0; sent = 0; dones = 0;
        data_in = words[0]; dv = 1'b1;
        prev_req = req; prev_hold = req | ack; prev_bus = bus;
        for (int c = 0; c < 200 && dones < 2; c++) begin
            acc  = ready && dv;
            busy = dv && !ready;
            @(negedge clk);
            check("b2b_dropped", dropped, busy);
            if (prev_hold) check("b2b_hold", bus, prev_bus);
            if (req && !prev_req) begin
                if (sent < 2) check("b2b_word", bus, words[sent]);
                else check("b2b_extra_req", 1, 0);
                sent++;
            end
            if (done) dones++;
            if (acc) begin
                idx++;
                if (idx < 2) data_in = words[idx];
                else dv = 1'b0;
            end
            prev_req = req; prev_hold = req | ack; prev_bus = bus;
        end
        check("b2b_dones", dones, 2);
        check("b2b_sent", sent, 2);
        dest_en = 1'b0;
        dv = 1'b0;
        nclk(4);
        // 5. timeout on both ack edges (ack stuck high for the return phase)
        data_in = 8'h77; dv2 = 1'b1;
        nclk(1);
        dv2 = 1'b0;
        check("to_req", req2, 1);
        check("to_bus", bus2, 8'h77);
        nclk(14);
        ack2 = 1'b1;
        nclk(1);
        check("to_req_hold", req2, 1);
        check("to_terr_early", terr2, 0);
        nclk(1);
        check("to_terr1", terr2, 1);
        check("to_req_fall", req2, 0);
        check("to_ready_lo", ready2, 0);
        nclk(1);
        check("to_terr1_clr", terr2, 0);
        nclk(14);
        check("to_terr2_early", terr2, 0);
        check("to_ready_wait", ready2, 0);
        nclk(1);
        check("to_terr2", terr2, 1);
        check("to_ready", ready2, 1);
        check("to_no_done", done2, 0);
        nclk(1);
        check("to_terr2_clr", terr2, 0);
        check("to_no_done2", done2, 0);
        ack2 = 1'b0;
        nclk(4);
        // 6. reset in REQ_LO, then a clean transfer
        data_in = 8'hC3; dv = 1'b1;
        nclk(1);
        dv = 1'b0;
        ack_man = 1'b1;
        nclk(3);
        check("mid_req_lo", req, 0);
        check("mid_ready_lo", ready, 0);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_ready", ready, 1);
        check("mid_rst_req", req, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_bus", bus, 0);
        @(negedge clk);
        ack_man = 1'b0;
        nclk(3);
        reset_n = 1'b1;
        nclk(2);
        data_in = 8'h5A; dv = 1'b1;
        nclk(1);
        dv = 1'b0;
        check("post_req", req, 1);
        check("post_bus", bus, 8'h5A);
        ack_man = 1'b1;
        nclk(3);
        check("post_req_fall", req, 0);
        ack_man = 1'b0;
        nclk(3);
        check("post_done", done, 1);
        check("post_bus_done", bus, 8'h5A);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
